// File: rtl/id_ex_pipe.sv
// id_ex_pipe: elastic ID/EX pipeline register with optional skid buffer, flush, delay-slot tagging and stall counter
module id_ex_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REGA_W   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int WREG_W   = 1,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [REGA_W-1:0]   id_wd,
  input  logic [WREG_W-1:0]   id_wreg,
  input  logic [DATA_W-1:0]   id_return_addr,
  input  logic [DATA_W-1:0]   id_inst,
  input  logic [ADDR_W-1:0]   id_pc,
  input  logic                id_is_branch,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [REGA_W-1:0]   ex_wd,
  output logic [WREG_W-1:0]   ex_wreg,
  output logic [DATA_W-1:0]   ex_return_addr,
  output logic [DATA_W-1:0]   ex_inst,
  output logic [ADDR_W-1:0]   ex_pc,
  output logic                ex_in_delayslot,
  output logic [CNT_W-1:0]    stall_cnt
);
  localparam int PW = ALUOP_W + ALUSEL_W + 4 * DATA_W + REGA_W + WREG_W + ADDR_W + 1;
  logic [PW-1:0] main_pl, skid_pl, in_pl;
  logic main_valid, skid_valid, ds_pend, acc, cons;
  assign in_pl = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_return_addr, id_inst, id_pc, ds_pend};
  assign id_ready = rst && (SKID != 0 ? !skid_valid : (!main_valid || ex_ready));
  assign acc = id_valid && id_ready;
  assign cons = main_valid && ex_ready;
  assign ex_valid = main_valid;
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_return_addr, ex_inst, ex_pc, ex_in_delayslot} = main_pl;
  // Entry movement: skid drains into main first so order stays FIFO; an empty main holds an all-zero payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_pl    <= '0;
      skid_valid <= 1'b0;
      skid_pl    <= '0;
      ds_pend    <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_pl    <= '0;
      skid_valid <= 1'b0;
      skid_pl    <= '0;
      ds_pend    <= 1'b0;
    end else begin
      if (!main_valid || cons) begin
        main_valid <= skid_valid || acc;
        main_pl    <= skid_valid ? skid_pl : acc ? in_pl : '0;
        skid_valid <= 1'b0;
      end else if (acc && SKID != 0) begin
        skid_valid <= 1'b1;
        skid_pl    <= in_pl;
      end
      if (acc) ds_pend <= id_is_branch;
    end
  end
  // Back-pressure counter saturates and ignores flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (main_valid && !ex_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: randomized and directed check of SKID=1 and SKID=0 builds against a queue model
module tb_id_ex_pipe;
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic [0:0]  wreg;
    logic [31:0] ra, inst, pc;
    logic        ds;
  } ent_t;
  logic clk = 0, rst, flush, id_valid, ex_ready, id_is_branch;
  logic [7:0] id_aluop;
  logic [2:0] id_alusel;
  logic [31:0] id_reg1, id_reg2, id_return_addr, id_inst, id_pc;
  logic [4:0] id_wd;
  logic [0:0] id_wreg;
  logic a_rdy, a_valid, a_ds, b_rdy, b_valid, b_ds;
  logic [7:0] a_aluop, b_aluop;
  logic [2:0] a_alusel, b_alusel;
  logic [31:0] a_reg1, a_reg2, a_ra, a_inst, a_pc, b_reg1, b_reg2, b_ra, b_inst, b_pc;
  logic [4:0] a_wd, b_wd;
  logic [0:0] a_wreg, b_wreg;
  logic [3:0] a_stall, b_stall;
  ent_t act_a, act_b;
  ent_t q[2][$];
  bit pnd[2];
  int cnt[2];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  id_ex_pipe #(.SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(a_rdy),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg), .id_return_addr(id_return_addr), .id_inst(id_inst),
    .id_pc(id_pc), .id_is_branch(id_is_branch), .ex_valid(a_valid), .ex_ready(ex_ready),
    .ex_aluop(a_aluop), .ex_alusel(a_alusel), .ex_reg1(a_reg1), .ex_reg2(a_reg2),
    .ex_wd(a_wd), .ex_wreg(a_wreg), .ex_return_addr(a_ra), .ex_inst(a_inst), .ex_pc(a_pc),
    .ex_in_delayslot(a_ds), .stall_cnt(a_stall));
  id_ex_pipe #(.SKID(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(b_rdy),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg), .id_return_addr(id_return_addr), .id_inst(id_inst),
    .id_pc(id_pc), .id_is_branch(id_is_branch), .ex_valid(b_valid), .ex_ready(ex_ready),
    .ex_aluop(b_aluop), .ex_alusel(b_alusel), .ex_reg1(b_reg1), .ex_reg2(b_reg2),
    .ex_wd(b_wd), .ex_wreg(b_wreg), .ex_return_addr(b_ra), .ex_inst(b_inst), .ex_pc(b_pc),
    .ex_in_delayslot(b_ds), .stall_cnt(b_stall));
  assign act_a = {a_aluop, a_alusel, a_reg1, a_reg2, a_wd, a_wreg, a_ra, a_inst, a_pc, a_ds};
  assign act_b = {b_aluop, b_alusel, b_reg1, b_reg2, b_wd, b_wreg, b_ra, b_inst, b_pc, b_ds};

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(bit v, logic [31:0] pc, bit br);
    id_valid = v;
    id_pc = pc;
    id_is_branch = br;
    id_aluop = 8'($urandom);
    id_alusel = 3'($urandom);
    id_reg1 = $urandom;
    id_reg2 = $urandom;
    id_wd = 5'($urandom);
    id_wreg = 1'($urandom);
    id_return_addr = $urandom;
    id_inst = $urandom;
  endtask

  function automatic ent_t cur_in(bit ds);
    ent_t e;
    e.aluop = id_aluop; e.alusel = id_alusel; e.reg1 = id_reg1; e.reg2 = id_reg2;
    e.wd = id_wd; e.wreg = id_wreg; e.ra = id_return_addr; e.inst = id_inst; e.pc = id_pc; e.ds = ds;
    return e;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      pnd[d] = 0;
      cnt[d] = 0;
    end
  endtask

  // One clock: check ready before the edge, advance the model at the edge, check outputs at the falling edge
  task automatic cyc();
    bit rdy[2];
    ent_t exp;
    #1;
    for (int d = 0; d < 2; d++) begin
      rdy[d] = rst && (d == 0 ? q[d].size() < 2 : (q[d].size() == 0 || ex_ready));
      chk(d == 0 ? "a_id_ready" : "b_id_ready", d == 0 ? a_rdy : b_rdy, rdy[d]);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        q[d].delete(); pnd[d] = 0; cnt[d] = 0;
      end else begin
        if (q[d].size() > 0 && !ex_ready && cnt[d] < 15) cnt[d]++;
        if (flush) begin
          q[d].delete(); pnd[d] = 0;
        end else begin
          if (q[d].size() > 0 && ex_ready) void'(q[d].pop_front());
          if (id_valid && rdy[d]) begin
            q[d].push_back(cur_in(pnd[d]));
            pnd[d] = id_is_branch;
          end
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp = q[d].size() > 0 ? q[d][0] : '0;
      chk(d == 0 ? "a_ex_valid" : "b_ex_valid", d == 0 ? a_valid : b_valid, q[d].size() > 0);
      chk(d == 0 ? "a_payload" : "b_payload", d == 0 ? act_a : act_b, exp);
      chk(d == 0 ? "a_stall_cnt" : "b_stall_cnt", d == 0 ? a_stall : b_stall, cnt[d]);
    end
  endtask

  initial begin
    rst = 0; flush = 0; ex_ready = 0;
    drive(0, 0, 0);
    model_clear();
    cyc(); cyc();
    chk("rst_valid", a_valid, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_ready", a_rdy, 0);
    rst = 1;
    ex_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 4 * i, 0);
      cyc();
      chk("b2b_pc", a_pc, 32'h100 + 4 * i);
      chk("b2b_valid", a_valid, 1);
    end
    drive(0, 0, 0); cyc();
    chk("b2b_stall", a_stall, 0);
    drive(1, 32'h100, 0); cyc();
    ex_ready = 0;
    drive(1, 32'h104, 0); cyc();
    drive(1, 32'h108, 0); cyc(); cyc();
    chk("hold_stall", a_stall, 3);
    chk("hold_pc", a_pc, 32'h100);
    chk("hold_ready", a_rdy, 0);
    ex_ready = 1;
    cyc();
    chk("rel_pc1", a_pc, 32'h104);
    cyc();
    chk("rel_pc2", a_pc, 32'h108);
    drive(0, 0, 0); cyc();
    drive(1, 32'h200, 1); cyc();
    chk("br_ds", a_ds, 0);
    drive(0, 0, 0); cyc(); cyc();
    drive(1, 32'h204, 0); cyc();
    chk("ds_pc", a_pc, 32'h204);
    chk("ds_flag", a_ds, 1);
    drive(1, 32'h208, 0); cyc();
    chk("post_ds_pc", a_pc, 32'h208);
    chk("post_ds_flag", a_ds, 0);
    ex_ready = 0;
    drive(1, 32'h300, 0); cyc();
    drive(1, 32'h304, 0); cyc();
    drive(1, 32'h308, 0); flush = 1; cyc();
    flush = 0;
    drive(0, 0, 0);
    chk("flush_valid", a_valid, 0);
    chk("flush_pl", act_a, 0);
    chk("flush_ready", a_rdy, 1);
    ex_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_gone", a_valid, 0);
    end
    drive(1, 32'h380, 0); cyc();
    drive(1, 32'h384, 0); ex_ready = 0; cyc();
    #2 rst = 0;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_pc", a_pc, 0);
    chk("arst_stall", a_stall, 0);
    chk("arst_ready", a_rdy, 0);
    model_clear();
    drive(0, 0, 0);
    cyc();
    rst = 1; ex_ready = 1;
    drive(1, 32'h400, 0); cyc();
    chk("arst_first_pc", a_pc, 32'h400);
    chk("arst_first_valid", a_valid, 1);
    ex_ready = 0;
    drive(1, 32'h500, 0); cyc();
    drive(0, 0, 0);
    repeat (20) cyc();
    chk("sat_a", a_stall, 15);
    chk("sat_b", b_stall, 15);
    ex_ready = 1; #1;
    chk("comb_ready_hi", b_rdy, 1);
    ex_ready = 0; #1;
    chk("comb_ready_lo", b_rdy, 0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
      ex_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      cyc();
    end
    flush = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
